// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALUOp codes,
// controller state encoding and the op-code support check.
package alu_arbiter_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_supported(input logic [3:0] op);
    logic sup;
    sup = 1'b0;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR: sup = 1'b1;
      default:                                    sup = 1'b0;
    endcase
    return sup;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// 64-bit combinational ALU. Unsupported codes produce a zero result;
// ADD/SUB wrap modulo 2^64 with no carry or overflow output.
module ALU_64_bit
  import alu_arbiter_pkg::*;
(
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic [3:0]  alu_op_i,
  output logic [63:0] result_o,
  output logic        zero_o
);

  // Operation select.
  always_comb begin
    result_o = '0;
    case (alu_op_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_NOR: result_o = ~(a_i | b_i);
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == 64'd0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared 64-bit ALU.
//
//   state   | meaning
//   IDLE    | waiting for a request; granted requester sees ready
//   EXEC    | latched operands drive the ALU; result registered at exit
//   RESP    | response held on rsp_* until rsp_ready
//
// Arbitration is round-robin on ties when RR_EN=1, otherwise requester 0
// always wins. The last-grant pointer resets to 1 so requester 0 wins the
// first tie.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter logic RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic        busy
);

  state_e      state_q, state_d;
  logic        last_q;
  logic        grant1;
  logic        accept;
  logic [63:0] a_q, b_q;
  logic [3:0]  op_q;
  logic        id_q;
  logic [63:0] rsp_result_q;
  logic        rsp_zero_q;
  logic        rsp_err_q;
  logic [63:0] alu_result;
  logic        alu_zero;
  logic        idle;

  assign idle = (state_q == ST_IDLE);

  // Grant selection; only meaningful while at least one requester is valid.
  always_comb begin
    grant1 = 1'b0;
    if (RR_EN) begin
      if (req0_valid && req1_valid) grant1 = ~last_q;
      else                          grant1 = req1_valid;
    end else begin
      grant1 = ~req0_valid;
    end
  end

  // Reset gates the readies so nothing looks accepted while held in reset.
  assign req0_ready = reset_n & idle & req0_valid & ~grant1;
  assign req1_ready = reset_n & idle & req1_valid &  grant1;
  assign accept     = req0_ready | req1_ready;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_EXEC;
      ST_EXEC:                state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // State register and last-grant pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) last_q <= grant1;
    end
  end

  // Capture the granted request's operands, op and id on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      id_q <= 1'b0;
    end else if (accept) begin
      a_q  <= grant1 ? req1_a  : req0_a;
      b_q  <= grant1 ? req1_b  : req0_b;
      op_q <= grant1 ? req1_op : req0_op;
      id_q <= grant1;
    end
  end

  ALU_64_bit u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .alu_op_i (op_q),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  // Register the ALU outcome on the EXEC->RESP edge; unsupported ops
  // report zero result and a clear Zero flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      if (op_supported(op_q)) begin
        rsp_result_q <= alu_result;
        rsp_zero_q   <= alu_zero;
        rsp_err_q    <= 1'b0;
      end else begin
        rsp_result_q <= '0;
        rsp_zero_q   <= 1'b0;
        rsp_err_q    <= 1'b1;
      end
    end
  end

  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = ~idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance plus a
// fixed-priority instance sharing the same stimulus.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        r0v, r1v, rsp_ready;
  logic [63:0] r0a, r0b, r1a, r1b;
  logic [3:0]  r0op, r1op;

  logic        rr_r0rdy, rr_r1rdy, rr_vld, rr_id, rr_zero, rr_err, rr_busy;
  logic [63:0] rr_res;
  logic        fp_r0rdy, fp_r1rdy, fp_vld, fp_id, fp_zero, fp_err, fp_busy;
  logic [63:0] fp_res;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(r0v), .req0_ready(rr_r0rdy), .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
    .req1_valid(r1v), .req1_ready(rr_r1rdy), .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
    .rsp_valid(rr_vld), .rsp_ready(rsp_ready), .rsp_id(rr_id), .rsp_result(rr_res),
    .rsp_zero(rr_zero), .rsp_err(rr_err), .busy(rr_busy)
  );

  alu_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(r0v), .req0_ready(fp_r0rdy), .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
    .req1_valid(r1v), .req1_ready(fp_r1rdy), .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
    .rsp_valid(fp_vld), .rsp_ready(rsp_ready), .rsp_id(fp_id), .rsp_result(fp_res),
    .rsp_zero(fp_zero), .rsp_err(fp_err), .busy(fp_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [63:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  task automatic do_reset();
    r0v = 1'b0; r1v = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int n_rr;
    int n_fp;
    reset_n = 1'b0;
    r0v = 1'b0; r1v = 1'b0; rsp_ready = 1'b0;
    r0a = '0; r0b = '0; r1a = '0; r1b = '0; r0op = '0; r1op = '0;

    vecs[0] = '{1'b0, 64'h0000000AB000000F, 64'h0002300000000F0F, 4'b0000, 64'h000000000000000F, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 64'h0000000AB000000F, 64'h0002300000000F0F, 4'b0010, 64'h0002300AB0000F1E, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 64'h0000000AB000000F, 64'h0002300000000F0F, 4'b0001, 64'h0002300AB0000F0F, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 64'h0000000000001234, 64'h0000000000001234, 4'b0110, 64'h0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 64'h0000000000001234, 64'h0000000000001234, 4'b0101, 64'h0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 64'h0, 64'h0, 4'b1100, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 64'h0, 64'h1, 4'b0110, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h1, 4'b0010, 64'h0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 64'h5, 64'h7, 4'b1111, 64'h0, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 4'b0000, 64'h0, 1'b1, 1'b0};

    // Reset state
    #1;
    chk("rst_valid", rr_vld, 0);
    chk("rst_busy", rr_busy, 0);
    chk("rst_result", rr_res, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven single-requester operations
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      if (vecs[i].sel) begin
        r1v = 1'b1; r1a = vecs[i].a; r1b = vecs[i].b; r1op = vecs[i].op;
      end else begin
        r0v = 1'b1; r0a = vecs[i].a; r0b = vecs[i].b; r0op = vecs[i].op;
      end
      #1;
      chk($sformatf("v%0d_ready0", i), rr_r0rdy, !vecs[i].sel);
      chk($sformatf("v%0d_ready1", i), rr_r1rdy, vecs[i].sel);
      @(posedge clk); #1;
      r0v = 1'b0; r1v = 1'b0;
      r0a = 64'hDEADBEEFDEADBEEF; r1a = 64'hDEADBEEFDEADBEEF; r0op = 4'b0010; r1op = 4'b0001;
      chk($sformatf("v%0d_exec_busy", i), rr_busy, 1);
      chk($sformatf("v%0d_exec_valid", i), rr_vld, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_rsp_valid", i), rr_vld, 1);
      chk($sformatf("v%0d_rsp_id", i), rr_id, vecs[i].sel);
      chk($sformatf("v%0d_rsp_result", i), rr_res, vecs[i].res);
      chk($sformatf("v%0d_rsp_zero", i), rr_zero, vecs[i].zero);
      chk($sformatf("v%0d_rsp_err", i), rr_err, vecs[i].err);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_busy", i), rr_busy, 0);
      rsp_ready = 1'b0;
    end

    // Both requesters valid continuously: RR alternates, fixed picks req0
    do_reset();
    r0a = 64'h1; r0b = 64'h1; r0op = 4'b0010;
    r1a = 64'h2; r1b = 64'h2; r1op = 4'b0010;
    r0v = 1'b1; r1v = 1'b1; rsp_ready = 1'b1;
    n_rr = 0; n_fp = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      chk("rr_one_ready", rr_r0rdy & rr_r1rdy, 0);
      if (rr_vld) begin
        chk($sformatf("rr_grant%0d", n_rr), rr_id, n_rr % 2);
        n_rr++;
      end
      if (fp_vld) begin
        chk($sformatf("fp_grant%0d", n_fp), fp_id, 0);
        n_fp++;
      end
    end
    chk("rr_resp_count", n_rr >= 4, 1);
    chk("fp_resp_count", n_fp >= 4, 1);

    // Consumer stall in RESP
    do_reset();
    r0a = 64'h1; r0b = 64'h2; r0op = 4'b0010;
    r1a = 64'h5; r1b = 64'h6; r1op = 4'b0010;
    r0v = 1'b1; r1v = 1'b1; rsp_ready = 1'b0;
    #1;
    chk("stall_tie_ready0", rr_r0rdy, 1);
    chk("stall_tie_ready1", rr_r1rdy, 0);
    @(posedge clk); #1;
    r0v = 1'b0;
    @(posedge clk); #1;
    chk("stall_rsp_valid", rr_vld, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_valid", k), rr_vld, 1);
      chk($sformatf("stall%0d_result", k), rr_res, 64'h3);
      chk($sformatf("stall%0d_id", k), rr_id, 0);
      chk($sformatf("stall%0d_readies", k), {rr_r0rdy, rr_r1rdy}, 2'b00);
      chk($sformatf("stall%0d_busy", k), rr_busy, 1);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("stall_hs_ready1", rr_r1rdy, 0);
    @(posedge clk); #1;
    chk("stall_after_busy", rr_busy, 0);
    chk("stall_after_valid", rr_vld, 0);
    chk("stall_after_ready1", rr_r1rdy, 1);
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    r1v = 1'b0;
    chk("stall_next_busy", rr_busy, 1);
    @(posedge clk); #1;
    chk("stall_next_result", rr_res, 64'hB);
    chk("stall_next_id", rr_id, 1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    // Reset in EXEC discards the operation
    @(negedge clk);
    r0a = 64'h3; r0b = 64'h4; r0op = 4'b0001; r0v = 1'b1;
    @(posedge clk); #1;
    r0v = 1'b0;
    chk("rexec_busy", rr_busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rexec_busy0", rr_busy, 0);
    chk("rexec_valid0", rr_vld, 0);
    chk("rexec_id0", rr_id, 0);
    chk("rexec_result0", rr_res, 0);
    chk("rexec_zero0", rr_zero, 0);
    chk("rexec_err0", rr_err, 0);
    r0v = 1'b1; r1v = 1'b1;
    #1;
    chk("rexec_readies_in_reset", {rr_r0rdy, rr_r1rdy}, 2'b00);
    r0v = 1'b0; r1v = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rexec_norsp%0d", k), rr_vld, 0);
    end
    @(negedge clk);
    r0v = 1'b1; r1v = 1'b1;
    #1;
    chk("rexec_tie_ready0", rr_r0rdy, 1);
    chk("rexec_tie_ready1", rr_r1rdy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, arbitration mode; 1 = round-robin, 0 = fixed priority to requester 0.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  64 each  requester 0 operands.
REQ-007 req0_op  input  4  requester 0 ALUOp code.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op  as REQ-004..007, requester 1.
REQ-009 rsp_valid  output  1  response held on rsp_* outputs.
REQ-010 rsp_ready  input  1  consumer accepts response.
REQ-011 rsp_id  output  1  index of requester owning the response.
REQ-012 rsp_result  output  64  ALU Result for the accepted operation.
REQ-013 rsp_zero  output  1  ALU Zero flag for the accepted operation.
REQ-014 rsp_err  output  1  accepted op code not supported.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 Supported codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR; every other code is unsupported.
REQ-017 FSM states IDLE, EXEC, RESP; IDLE->EXEC on accept; EXEC->RESP unconditionally; RESP->IDLE when rsp_ready=1, else stay RESP.
REQ-018 reqN_ready is combinational, high only in IDLE for the granted requester; at most one ready high per cycle.
REQ-019 Accept = reqN_valid & reqN_ready at a rising edge; operands, op and id latched into internal registers at that edge.
REQ-020 Arbitration with RR_EN=1: single valid requester is granted; both valid grants the requester not granted last; last-grant pointer updates only on accept.
REQ-021 Arbitration with RR_EN=0: req0 granted whenever req0_valid=1, else req1.
REQ-022 In EXEC the latched operands drive the ALU; Result and Zero are registered into rsp_result/rsp_zero at the EXEC->RESP edge.
REQ-023 Latency: rsp_valid rises exactly 2 clock edges after the accept edge; throughput one operation per 3 cycles minimum.
REQ-024 Unsupported op: rsp_result=0, rsp_zero=0, rsp_err=1; same latency and handshake as a supported op.
REQ-025 rsp_valid, rsp_id, rsp_result, rsp_zero and rsp_err stay stable throughout RESP until the handshake completes.
REQ-026 No request is accepted in EXEC or RESP, including the RESP cycle in which rsp_ready=1; new accept occurs at the earliest in the following IDLE cycle.
REQ-027 Input changes on an un-accepted request have no effect; requests are never dropped while reqN_valid is held.
REQ-028 Width rule: ADD/SUB wrap modulo 2^64; no carry or overflow output.

Reset
REQ-029 reset_n low forces IDLE asynchronously: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, busy=0; last-grant pointer=1, so req0 wins the first tie.
REQ-030 Reset during EXEC or RESP discards the in-flight operation; no response is produced for it after reset release.
REQ-031 reqN_ready is 0 while reset_n is low.

Structure
REQ-032 Shared package holds the ALUOp code constants (AND, OR, ADD, SUB, NOR) and the FSM state enumeration.
REQ-033 One sub-module: the existing ALU_64_bit, instantiated once and driven only from the latched operand registers.

Verification
REQ-034 req0 only, a=0x0000000AB000000F, b=0x0002300000000F0F, op=0000 -> rsp_valid 2 edges after accept, rsp_id=0, rsp_result=0x000000000000000F, rsp_zero=0, rsp_err=0.
REQ-035 Same operands, op=0010 on req1 -> rsp_id=1, rsp_result=0x0002300AB0000F1E.
REQ-036 Both valid continuously, RR_EN=1, rsp_ready=1 -> grants alternate 0,1,0,1; with RR_EN=0 -> req0 granted every time.
REQ-037 op=0110 with a=b=0x1234 -> rsp_result=0, rsp_zero=1; op=0101 -> rsp_err=1, rsp_result=0.
REQ-038 rsp_ready held low 5 cycles in RESP -> rsp_* stable, both readies low, busy=1; no second accept until the cycle after the handshake.
REQ-039 reset_n pulsed low during EXEC -> all outputs return to reset values immediately; no response for the discarded op; the next tie is granted to req0.
